// File: rtl/mux_tdm_scanner.sv
// Registered N:1 channel multiplexer with manual select and masked round-robin
// auto-scan, presented to a single consumer over a valid/ready handshake.
module mux_tdm_scanner #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_CHANNELS = 32,
    parameter int SEL_WIDTH    = 5,
    parameter int DWELL_WIDTH  = 8
) (
    input  logic                               Clock_In,
    input  logic                               Reset_n_In,
    input  logic                               Enable_In,
    input  logic                               Mode_In,
    input  logic [SEL_WIDTH-1:0]               Select_In,
    input  logic [NUM_CHANNELS-1:0]            Channel_Mask_In,
    input  logic [DWELL_WIDTH-1:0]             Dwell_In,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] Data_In,
    input  logic                               Ready_In,
    output logic [DATA_WIDTH-1:0]              MUX_Data_Out,
    output logic [SEL_WIDTH-1:0]               Channel_Out,
    output logic                               Valid_Out
);
    typedef enum logic [1:0] {IDLE, MANUAL, SCAN_PRESENT, SCAN_DWELL} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [SEL_WIDTH-1:0]    chan_q, chan_d;
    logic [SEL_WIDTH-1:0]    ptr_q, ptr_d;
    logic                    valid_q, valid_d;
    logic [DWELL_WIDTH-1:0]  dwell_q, dwell_d;

    logic [DATA_WIDTH-1:0]   chan_data [NUM_CHANNELS];
    logic [SEL_WIDTH-1:0]    ptr_next;
    logic [SEL_WIDTH:0]      hit_cur, hit_next;
    logic                    sel_ok;
    logic [SEL_WIDTH-1:0]    sel_idx;
    logic                    man_load, scan_load;
    logic [SEL_WIDTH-1:0]    scan_idx;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_unpack
        assign chan_data[g] = Data_In[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Returns {found, index} of the first masked-in channel at or after start, wrapping.
    function automatic logic [SEL_WIDTH:0] first_set(input logic [NUM_CHANNELS-1:0] mask,
                                                     input logic [SEL_WIDTH-1:0]    start);
        logic [SEL_WIDTH:0] hit;
        int unsigned        idx;
        hit = '0;
        for (int unsigned k = NUM_CHANNELS; k > 0; k--) begin
            idx = 32'(start) + k - 1;
            if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
            if (mask[SEL_WIDTH'(idx)]) hit = {1'b1, SEL_WIDTH'(idx)};
        end
        return hit;
    endfunction

    assign ptr_next = (32'(ptr_q) + 1 >= NUM_CHANNELS) ? '0 : ptr_q + 1'b1;
    assign hit_cur  = first_set(Channel_Mask_In, ptr_q);
    assign hit_next = first_set(Channel_Mask_In, ptr_next);
    assign sel_ok   = 32'(Select_In) < NUM_CHANNELS;
    assign sel_idx  = sel_ok ? Select_In : '0;

    always_ff @(posedge Clock_In) begin
        if (!Reset_n_In) begin
            state_q <= IDLE;
            data_q  <= '0;
            chan_q  <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            dwell_q <= dwell_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        chan_d    = chan_q;
        ptr_d     = ptr_q;
        valid_d   = valid_q;
        dwell_d   = dwell_q;
        man_load  = 1'b0;
        scan_load = 1'b0;
        scan_idx  = '0;

        if (!Enable_In) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Manual entry captures on the same edge to keep one-cycle latency.
                    if (!Mode_In) begin
                        state_d  = MANUAL;
                        man_load = 1'b1;
                    end else if (hit_cur[SEL_WIDTH]) begin
                        scan_load = 1'b1;
                        scan_idx  = hit_cur[SEL_WIDTH-1:0];
                    end
                end
                MANUAL: begin
                    if (!valid_q || Ready_In) begin
                        if (Mode_In) begin
                            valid_d = 1'b0;
                            state_d = IDLE;
                        end else begin
                            man_load = 1'b1;
                        end
                    end
                end
                SCAN_PRESENT: begin
                    if (Ready_In) begin
                        if (!Mode_In) begin
                            valid_d = 1'b0;
                            state_d = IDLE;
                        end else if (Dwell_In == '0) begin
                            if (hit_next[SEL_WIDTH]) begin
                                scan_load = 1'b1;
                                scan_idx  = hit_next[SEL_WIDTH-1:0];
                            end else begin
                                valid_d = 1'b0;
                                state_d = IDLE;
                            end
                        end else begin
                            valid_d = 1'b0;
                            dwell_d = Dwell_In;
                            state_d = SCAN_DWELL;
                        end
                    end
                end
                SCAN_DWELL: begin
                    if (dwell_q > DWELL_WIDTH'(1)) begin
                        dwell_d = dwell_q - 1'b1;
                    end else begin
                        dwell_d = '0;
                        if (Mode_In && hit_next[SEL_WIDTH]) begin
                            scan_load = 1'b1;
                            scan_idx  = hit_next[SEL_WIDTH-1:0];
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (man_load) begin
            chan_d = Select_In;
            if (sel_ok) begin
                data_d  = chan_data[sel_idx];
                valid_d = 1'b1;
            end else begin
                data_d  = '0;
                valid_d = 1'b0;
            end
        end
        if (scan_load) begin
            data_d  = chan_data[scan_idx];
            chan_d  = scan_idx;
            ptr_d   = scan_idx;
            valid_d = 1'b1;
            state_d = SCAN_PRESENT;
        end
    end

    assign MUX_Data_Out = data_q;
    assign Channel_Out  = chan_q;
    assign Valid_Out    = valid_q;
endmodule

// File: tb/tb_mux_tdm_scanner.sv
// Bench for mux_tdm_scanner: directed scenarios plus randomized traffic, each cycle
// compared against a behavioural model for a 32-channel and a 20-channel instance.
module tb_mux_tdm_scanner;
    localparam int DW = 8;
    localparam int N0 = 32;
    localparam int N1 = 20;
    localparam int SW = 5;
    localparam int WW = 8;

    localparam int PH_IDLE = 0;
    localparam int PH_MAN  = 1;
    localparam int PH_PRES = 2;
    localparam int PH_GAP  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, en, mode, rdy;
    logic [SW-1:0] sel;
    logic [N0-1:0] mask;
    logic [WW-1:0] dwell;
    logic [DW-1:0] chd [N0];
    logic [N0*DW-1:0] data_in;

    logic [DW-1:0] d0, d1;
    logic [SW-1:0] c0, c1;
    logic          v0, v1;

    always_comb begin
        data_in = '0;
        for (int i = 0; i < N0; i++) data_in[i*DW +: DW] = chd[i];
    end

    mux_tdm_scanner #(.DATA_WIDTH(DW), .NUM_CHANNELS(N0), .SEL_WIDTH(SW), .DWELL_WIDTH(WW)) u_dut (
        .Clock_In(clk), .Reset_n_In(rst_n), .Enable_In(en), .Mode_In(mode),
        .Select_In(sel), .Channel_Mask_In(mask), .Dwell_In(dwell), .Data_In(data_in),
        .Ready_In(rdy), .MUX_Data_Out(d0), .Channel_Out(c0), .Valid_Out(v0));

    mux_tdm_scanner #(.DATA_WIDTH(DW), .NUM_CHANNELS(N1), .SEL_WIDTH(SW), .DWELL_WIDTH(WW)) u_dut20 (
        .Clock_In(clk), .Reset_n_In(rst_n), .Enable_In(en), .Mode_In(mode),
        .Select_In(sel), .Channel_Mask_In(mask[N1-1:0]), .Dwell_In(dwell),
        .Data_In(data_in[N1*DW-1:0]), .Ready_In(rdy),
        .MUX_Data_Out(d1), .Channel_Out(c1), .Valid_Out(v1));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: one entry per instance.
    int          nch    [2];
    int          m_ph   [2];
    int          m_ptr  [2];
    int          m_wait [2];
    int          m_ch   [2];
    int          m_d    [2];
    bit          m_v    [2];

    function automatic int find_ch(int n, int start);
        for (int k = 0; k < n; k++) begin
            int c;
            c = (start + k) % n;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    task automatic present(int u, int c);
        m_d[u] = chd[c]; m_ch[u] = c; m_ptr[u] = c; m_v[u] = 1; m_ph[u] = PH_PRES;
    endtask

    task automatic manual_take(int u);
        m_ch[u] = sel;
        if (int'(sel) < nch[u]) begin m_d[u] = chd[sel]; m_v[u] = 1; end
        else begin m_d[u] = 0; m_v[u] = 0; end
    endtask

    task automatic model_step(int u);
        int n, c;
        n = nch[u];
        if (!rst_n) begin
            m_ph[u] = PH_IDLE; m_v[u] = 0; m_d[u] = 0; m_ch[u] = 0; m_ptr[u] = 0; m_wait[u] = 0;
            return;
        end
        if (!en) begin m_ph[u] = PH_IDLE; m_v[u] = 0; return; end
        case (m_ph[u])
            PH_IDLE: begin
                if (!mode) begin m_ph[u] = PH_MAN; manual_take(u); end
                else begin c = find_ch(n, m_ptr[u]); if (c >= 0) present(u, c); end
            end
            PH_MAN: if (!m_v[u] || rdy) begin
                if (mode) begin m_v[u] = 0; m_ph[u] = PH_IDLE; end
                else manual_take(u);
            end
            PH_PRES: if (rdy) begin
                if (!mode) begin m_v[u] = 0; m_ph[u] = PH_IDLE; end
                else if (dwell == 0) begin
                    c = find_ch(n, (m_ptr[u] + 1) % n);
                    if (c >= 0) present(u, c); else begin m_v[u] = 0; m_ph[u] = PH_IDLE; end
                end else begin
                    m_v[u] = 0; m_wait[u] = int'(dwell); m_ph[u] = PH_GAP;
                end
            end
            default: begin
                m_wait[u]--;
                if (m_wait[u] == 0) begin
                    c = mode ? find_ch(n, (m_ptr[u] + 1) % n) : -1;
                    if (c >= 0) present(u, c); else m_ph[u] = PH_IDLE;
                end
            end
        endcase
    endtask

    int acc_ch  [$];
    int acc_cyc [$];

    task automatic tick();
        if (v0 && rdy) begin acc_ch.push_back(int'(c0)); acc_cyc.push_back(cyc); end
        @(posedge clk);
        cyc++;
        model_step(0);
        model_step(1);
        #1;
        check("valid", v0, m_v[0]);
        check("data", d0, m_d[0]);
        check("chan", c0, m_ch[0]);
        check("valid20", v1, m_v[1]);
        check("data20", d1, m_d[1]);
        check("chan20", c1, m_ch[1]);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seq_exp [5];
        int rot_exp [3];
        bit reached;
        nch[0] = N0; nch[1] = N1;
        rst_n = 0; en = 0; mode = 0; rdy = 0; sel = '0; mask = '0; dwell = '0;
        for (int i = 0; i < N0; i++) chd[i] = 8'(8'h40 + i);
        repeat (2) tick();
        check("rst_data", d0, 0); check("rst_chan", c0, 0); check("rst_valid", v0, 0);

        rst_n = 1; en = 1; mode = 0; rdy = 1; sel = 5'd7;
        tick();
        check("man_sel7", d0, 32'h47); check("man_ch7", c0, 7); check("man_v7", v0, 1);
        sel = 5'd31; tick();
        check("man_sel31", d0, 32'h5F); check("man_ch31", c0, 31);
        check("oor31_valid20", v1, 0); check("oor31_data20", d1, 0);
        sel = 5'd3; tick();
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            sel = 5'(5 + 2 * i);
            tick();
            check("bp_hold_data", d0, 32'h43); check("bp_hold_chan", c0, 3); check("bp_hold_v", v0, 1);
        end
        rdy = 1; sel = 5'd25; tick();
        check("oor25_valid20", v1, 0); check("oor25_data20", d1, 0); check("sel25_data", d0, 32'h59);

        // Auto-scan with dwell gap of 2.
        mode = 1; dwell = 8'd2; mask = 32'h8000_0005;
        tick();
        acc_ch.delete(); acc_cyc.delete();
        repeat (16) tick();
        seq_exp = '{0, 2, 31, 0, 2};
        check("scan_count", (acc_ch.size() >= 5) ? 1 : 0, 1);
        for (int i = 0; i < 5 && i < acc_ch.size(); i++) begin
            check("scan_seq", acc_ch[i], seq_exp[i]);
            if (i > 0) check("scan_gap", acc_cyc[i] - acc_cyc[i-1], 3);
        end

        // Back-to-back scan with zero dwell.
        dwell = 8'd0;
        acc_ch.delete(); acc_cyc.delete();
        repeat (4) tick();
        rot_exp = '{31, 0, 2};
        check("b2b_count", (acc_ch.size() >= 3) ? 1 : 0, 1);
        for (int i = 0; i < 3 && i < acc_ch.size(); i++) begin
            check("b2b_seq", acc_ch[i], rot_exp[i]);
            if (i > 0) check("b2b_gap", acc_cyc[i] - acc_cyc[i-1], 1);
        end

        // Empty mask keeps the block idle.
        mask = '0; repeat (2) tick();
        en = 0; tick(); en = 1;
        repeat (3) begin tick(); check("empty_mask_v", v0, 0); end

        // Enable drop with a pending beat.
        mask = 32'h8000_0005; rdy = 0; repeat (2) tick();
        check("pend_v", v0, 1);
        en = 0; tick(); check("drop_v", v0, 0);
        en = 1; tick(); check("reen_v", v0, 1);

        // Mode switch with a pending beat.
        mode = 0; sel = 5'd12; tick(); check("mode_hold_v", v0, 1);
        rdy = 1; tick(); check("mode_idle_v", v0, 0);
        tick(); check("mode_man_v", v0, 1); check("mode_man_d", d0, int'(chd[12]));

        // Reset while dwelling.
        mode = 1; dwell = 8'd5; reached = 0;
        for (int i = 0; i < 20 && !reached; i++) begin
            tick();
            if (m_ph[0] == PH_GAP) reached = 1;
        end
        check("reach_dwell", reached, 1);
        rst_n = 0; tick();
        check("midrst_d", d0, 0); check("midrst_c", c0, 0); check("midrst_v", v0, 0);
        rst_n = 1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            en    = ($urandom_range(0, 49) != 0);
            rdy   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            sel   = 5'($urandom);
            if ($urandom_range(0, 29) == 0)
                mask = ($urandom_range(0, 5) == 0) ? '0 : ($urandom & $urandom);
            dwell = 8'($urandom_range(0, 3));
            for (int c = 0; c < N0; c++) chd[c] = 8'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
